// File: rtl/idu.sv
// idu: dual-issue dispatch, gates two decoded slots on RS availability and registers them
// Ports: clk, rst (sync, active-high); IDU_in_inst1_* / IDU_in_inst2_* decoded slots;
// AR_Status / MR_Status (1 = RS full); select_instruction {d2,d1}; IDU_out_inst1_* / IDU_out_inst2_*.
// Optional macro IDU_STATS_EN adds pos_count / neg_count dispatch statistics.
module idu #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] IDU_in_inst1_type,
  input  logic [W-1:0] IDU_in_inst1_destination_reg1,
  input  logic [W-1:0] IDU_in_inst1_source_reg1,
  input  logic [W-1:0] IDU_in_inst1_source_reg2,
  input  logic [W-1:0] IDU_in_inst2_type,
  input  logic [W-1:0] IDU_in_inst2_destination_reg2,
  input  logic [W-1:0] IDU_in_inst2_source_reg3,
  input  logic [W-1:0] IDU_in_inst2_source_reg4,
  input  logic         AR_Status,
  input  logic         MR_Status,
  output logic [1:0]   select_instruction,
  output logic [W-1:0] IDU_out_inst1_type,
  output logic [W-1:0] IDU_out_inst1_destination_reg1,
  output logic [W-1:0] IDU_out_inst1_source_reg1,
  output logic [W-1:0] IDU_out_inst1_source_reg2,
  output logic [W-1:0] IDU_out_inst2_type,
  output logic [W-1:0] IDU_out_inst2_destination_reg2,
  output logic [W-1:0] IDU_out_inst2_source_reg3,
  output logic [W-1:0] IDU_out_inst2_source_reg4
`ifdef IDU_STATS_EN
  ,
  output logic [3:0]   pos_count,
  output logic [3:0]   neg_count
`endif
);
  localparam logic [W-1:0] OP_ADD = W'(1);
  localparam logic [W-1:0] OP_SUB = W'(2);
  localparam logic [W-1:0] OP_MUL = W'(3);
  localparam logic [W-1:0] OP_DIV = W'(4);
  logic a1, m1, a2, m2, d1, d2;
  always_comb begin
    a1 = IDU_in_inst1_type == OP_ADD || IDU_in_inst1_type == OP_SUB;
    m1 = IDU_in_inst1_type == OP_MUL || IDU_in_inst1_type == OP_DIV;
    a2 = IDU_in_inst2_type == OP_ADD || IDU_in_inst2_type == OP_SUB;
    m2 = IDU_in_inst2_type == OP_MUL || IDU_in_inst2_type == OP_DIV;
    d1 = (a1 && !AR_Status) || (m1 && !MR_Status);
    // slot 2 needs slot 1 gone (empty or issued) and a class slot 1 did not just take
    d2 = ((a2 && !AR_Status) || (m2 && !MR_Status)) && (!(a1 || m1) || d1)
         && !(d1 && ((a1 && a2) || (m1 && m2)));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      select_instruction             <= '0;
      IDU_out_inst1_type             <= '0;
      IDU_out_inst1_destination_reg1 <= '0;
      IDU_out_inst1_source_reg1      <= '0;
      IDU_out_inst1_source_reg2      <= '0;
      IDU_out_inst2_type             <= '0;
      IDU_out_inst2_destination_reg2 <= '0;
      IDU_out_inst2_source_reg3      <= '0;
      IDU_out_inst2_source_reg4      <= '0;
    end else begin
      select_instruction             <= {d2, d1};
      IDU_out_inst1_type             <= d1 ? IDU_in_inst1_type : '0;
      IDU_out_inst1_destination_reg1 <= d1 ? IDU_in_inst1_destination_reg1 : '0;
      IDU_out_inst1_source_reg1      <= d1 ? IDU_in_inst1_source_reg1 : '0;
      IDU_out_inst1_source_reg2      <= d1 ? IDU_in_inst1_source_reg2 : '0;
      IDU_out_inst2_type             <= d2 ? IDU_in_inst2_type : '0;
      IDU_out_inst2_destination_reg2 <= d2 ? IDU_in_inst2_destination_reg2 : '0;
      IDU_out_inst2_source_reg3      <= d2 ? IDU_in_inst2_source_reg3 : '0;
      IDU_out_inst2_source_reg4      <= d2 ? IDU_in_inst2_source_reg4 : '0;
    end
  end
`ifdef IDU_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_count <= '0;
      neg_count <= '0;
    end else begin
      pos_count <= pos_count + {3'b0, d1} + {3'b0, d2};
      neg_count <= neg_count + {3'b0, ((a1 || m1) && !d1) || ((a2 || m2) && !d2)};
    end
  end
`endif
endmodule

// File: tb/tb_idu.sv
// tb_idu: directed self-checking bench for the idu dispatch unit
module tb_idu;
  logic clk = 0, rst = 1, ar = 0, mr = 0;
  logic [7:0] t1 = 0, dd1 = 0, s1 = 0, s2 = 0, t2 = 0, dd2 = 0, s3 = 0, s4 = 0;
  logic [1:0] sel;
  logic [7:0] o1t, o1d, o1a, o1b, o2t, o2d, o2a, o2b;
`ifdef IDU_STATS_EN
  logic [3:0] pos_count, neg_count;
`endif
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  idu dut (
    .clk(clk), .rst(rst),
    .IDU_in_inst1_type(t1), .IDU_in_inst1_destination_reg1(dd1),
    .IDU_in_inst1_source_reg1(s1), .IDU_in_inst1_source_reg2(s2),
    .IDU_in_inst2_type(t2), .IDU_in_inst2_destination_reg2(dd2),
    .IDU_in_inst2_source_reg3(s3), .IDU_in_inst2_source_reg4(s4),
    .AR_Status(ar), .MR_Status(mr), .select_instruction(sel),
    .IDU_out_inst1_type(o1t), .IDU_out_inst1_destination_reg1(o1d),
    .IDU_out_inst1_source_reg1(o1a), .IDU_out_inst1_source_reg2(o1b),
    .IDU_out_inst2_type(o2t), .IDU_out_inst2_destination_reg2(o2d),
    .IDU_out_inst2_source_reg3(o2a), .IDU_out_inst2_source_reg4(o2b)
`ifdef IDU_STATS_EN
    , .pos_count(pos_count), .neg_count(neg_count)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic r, input logic a, input logic m,
                      input logic [7:0] i1t, i1d, i1a, i1b, i2t, i2d, i2a, i2b);
    @(negedge clk);
    rst = r; ar = a; mr = m;
    t1 = i1t; dd1 = i1d; s1 = i1a; s2 = i1b; t2 = i2t; dd2 = i2d; s3 = i2a; s4 = i2b;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic expect_out(input string tag, input logic [1:0] es,
                            input logic [7:0] e1t, e1d, e1a, e1b, e2t, e2d, e2a, e2b);
    chk({tag, ".sel"}, 32'(sel), 32'(es));
    chk({tag, ".o1"}, {o1t, o1d, o1a, o1b}, {e1t, e1d, e1a, e1b});
    chk({tag, ".o2"}, {o2t, o2d, o2a, o2b}, {e2t, e2d, e2a, e2b});
  endtask
  initial begin
    step(1, 0, 0, 1, 9, 9, 9, 3, 9, 9, 9);
    step(1, 0, 0, 1, 9, 9, 9, 3, 9, 9, 9);
    expect_out("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 3, 2, 0, 1, 0, 0, 0, 0);
    expect_out("stall_full", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 3, 2, 0, 1, 1, 5, 3, 4);
    expect_out("dual", 3, 3, 2, 0, 1, 1, 5, 3, 4);
    step(0, 0, 0, 1, 8, 6, 7, 1, 11, 9, 10);
    expect_out("same_class", 1, 1, 8, 6, 7, 0, 0, 0, 0);
    step(0, 0, 1, 3, 14, 12, 13, 1, 17, 15, 16);
    expect_out("in_order", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 14, 12, 13, 1, 17, 15, 16);
    expect_out("nop_slot1", 2, 0, 0, 0, 0, 1, 17, 15, 16);
    step(0, 0, 0, 9, 1, 2, 3, 4, 6, 7, 8);
    expect_out("undef_slot1", 2, 0, 0, 0, 0, 4, 6, 7, 8);
    step(0, 1, 0, 4, 20, 21, 22, 2, 23, 24, 25);
    expect_out("div_sub_ar", 1, 4, 20, 21, 22, 0, 0, 0, 0);
    step(0, 0, 0, 2, 30, 31, 32, 4, 33, 30, 34);
    expect_out("dep_nostall", 3, 2, 30, 31, 32, 4, 33, 30, 34);
    step(0, 0, 0, 3, 1, 2, 3, 0, 9, 9, 9);
    expect_out("slot2_nop", 1, 3, 1, 2, 3, 0, 0, 0, 0);
    step(1, 0, 0, 3, 2, 0, 1, 1, 5, 3, 4);
    expect_out("mid_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 3, 2, 0, 1, 1, 5, 3, 4);
    expect_out("after_reset", 3, 3, 2, 0, 1, 1, 5, 3, 4);
`ifdef IDU_STATS_EN
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("stats.rst_pos", 32'(pos_count), 0);
    for (int i = 0; i < 9; i++) step(0, 0, 0, 3, 2, 0, 1, 1, 5, 3, 4);
    chk("stats.pos_wrap", 32'(pos_count), 2);
    chk("stats.neg_zero", 32'(neg_count), 0);
    step(0, 1, 1, 3, 2, 0, 1, 0, 0, 0, 0);
    chk("stats.neg_one", 32'(neg_count), 1);
    chk("stats.pos_hold", 32'(pos_count), 2);
    step(1, 0, 0, 3, 2, 0, 1, 1, 5, 3, 4);
    chk("stats.mid_rst_pos", 32'(pos_count), 0);
    chk("stats.mid_rst_neg", 32'(neg_count), 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
